// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave countdown timer.
//   BCD_W        width of one BCD digit
//   QUICK_TENS   seconds-tens digit loaded by quick start / added by +30 s
//   SEC_TENS_MAX largest legal seconds-tens digit while counting
//   state_t      controller state encoding (also driven on the state port)
package microwave_pkg;

    localparam int         BCD_W        = 4;
    localparam logic [3:0] QUICK_TENS   = 4'd3;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/microwave_countdown_bcd_down_digit.sv
// One BCD digit of the countdown chain.
//   clock, clear   rising-edge clock, synchronous active-high reset
//   load/value_in  parallel load (wins over decrement)
//   dec_en         decrement request from the digit below (or the seconds tick)
//   value          registered digit
//   value_dec      value after this cycle's decrement; the top level builds
//                  its +30 s result from these so a same-cycle tick is honoured
//   borrow_out     decrement wrapping 0 -> RADIX-1, feeds the next digit up
//   zero           value == 0
module bcd_down_digit
    import microwave_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] value_in,
    input  logic             dec_en,
    output logic [BCD_W-1:0] value,
    output logic [BCD_W-1:0] value_dec,
    output logic             borrow_out,
    output logic             zero
);

    localparam logic [BCD_W-1:0] TOP = BCD_W'(RADIX - 1);

    assign zero       = (value == '0);
    assign borrow_out = dec_en && zero;

    always_comb begin
        value_dec = value;
        if (dec_en) begin
            value_dec = zero ? TOP : value - BCD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= value_in;
        end else begin
            value <= value_dec;
        end
    end

endmodule

// File: rtl/microwave_countdown.sv
// M..M:SS microwave countdown timer with keypad entry, start/pause/cancel,
// quick start / +30 s, entry normalisation and a one-cycle done pulse.
//   clock, clear          rising-edge clock, synchronous active-high reset
//   digit_valid/digit_in  keypad BCD digit strobe (digits > 9 ignored)
//   start, stop           start/resume/+30 s and pause/cancel strobes
//   digits                BCD time, seconds ones in the low nibble
//   state, running, done  registered controller status
//   zero                  all digits zero (decoded from digits only)
//
// state   | meaning
// IDLE    | cleared, digits 0, waiting for keys or quick start
// ENTRY   | keypad digits being shifted in (sec tens may read 6..9)
// RUNNING | counting down one second per prescaler wrap
// PAUSED  | countdown frozen, digits and prescaler held
// DONE    | reached 0:00, done pulsed on entry
module microwave_countdown
    import microwave_pkg::*;
#(
    parameter int MIN_DIGITS    = 1,
    parameter int TICKS_PER_SEC = 100
) (
    input  logic                               clock,
    input  logic                               clear,
    input  logic                               digit_valid,
    input  logic [3:0]                         digit_in,
    input  logic                               start,
    input  logic                               stop,
    output logic [BCD_W*(MIN_DIGITS+2)-1:0]    digits,
    output logic [2:0]                         state,
    output logic                               running,
    output logic                               zero,
    output logic                               done
);

    localparam int ND = MIN_DIGITS + 2;
    localparam int DW = BCD_W * ND;
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] QUICK_VALUE = DW'({QUICK_TENS, 4'd0});
    localparam logic [DW-1:0] MAX_VALUE   = {{(ND-2){4'd9}}, SEC_TENS_MAX, 4'd9};

    state_t          state_q;
    logic [PW-1:0]   presc_q;
    logic            presc_run;
    logic            tick;
    logic            key_ok;
    logic            entry_ok;
    logic            load;
    logic [DW-1:0]   load_value;
    logic [DW-1:0]   dec_value;
    logic [DW-1:0]   sum_value;
    logic [ND:0]     dec_chain;
    logic [ND-1:0]   digit_zero;
    logic            dec_zero;
    logic            unused_top_borrow;
    logic [4:0]      tens_sum;
    logic            carry;

    assign state    = state_q;
    assign zero     = &digit_zero;
    assign key_ok   = digit_valid && (digit_in <= 4'd9);
    assign entry_ok = (state_q == IDLE) || (state_q == ENTRY) || (state_q == DONE);

    // Stop takes the cycle, so a pending wrap is held rather than applied.
    assign presc_run = (state_q == RUNNING) && !stop;
    assign tick      = presc_run && (presc_q == PRESC_LAST);

    assign dec_chain[0]      = tick;
    assign dec_zero          = (dec_value == '0);
    assign unused_top_borrow = dec_chain[ND];

    for (genvar g = 0; g < ND; g++) begin : g_digit
        localparam int RADIX = (g == 1) ? 6 : 10;
        bcd_down_digit #(.RADIX(RADIX)) u_digit (
            .clock      (clock),
            .clear      (clear),
            .load       (load),
            .value_in   (load_value[BCD_W*g +: BCD_W]),
            .dec_en     (dec_chain[g]),
            .value      (digits[BCD_W*g +: BCD_W]),
            .value_dec  (dec_value[BCD_W*g +: BCD_W]),
            .borrow_out (dec_chain[g+1]),
            .zero       (digit_zero[g])
        );
    end

    // Shared adder: +30 s while running, +0 s to normalise an entry such as
    // 0:90. Seconds tens never exceeds 12 here, so one subtraction suffices.
    always_comb begin
        sum_value = dec_value;
        carry     = 1'b0;
        tens_sum  = {1'b0, dec_value[7:4]}
                  + ((state_q == RUNNING) ? {1'b0, QUICK_TENS} : 5'd0);
        if (tens_sum > {1'b0, SEC_TENS_MAX}) begin
            tens_sum = tens_sum - ({1'b0, SEC_TENS_MAX} + 5'd1);
            carry    = 1'b1;
        end
        sum_value[7:4] = tens_sum[3:0];
        for (int i = 2; i < ND; i++) begin
            if (carry) begin
                if (dec_value[BCD_W*i +: BCD_W] == 4'd9) begin
                    sum_value[BCD_W*i +: BCD_W] = 4'd0;
                end else begin
                    sum_value[BCD_W*i +: BCD_W] = dec_value[BCD_W*i +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            sum_value = MAX_VALUE;
        end
    end

    always_comb begin
        load       = 1'b0;
        load_value = '0;
        if (stop) begin
            load = (state_q != RUNNING);
        end else if (start) begin
            case (state_q)
                IDLE, DONE: begin
                    load       = 1'b1;
                    load_value = QUICK_VALUE;
                end
                ENTRY: begin
                    load       = !zero;
                    load_value = sum_value;
                end
                RUNNING: begin
                    load       = 1'b1;
                    load_value = sum_value;
                end
                default: ;
            endcase
        end else if (key_ok && entry_ok) begin
            load       = 1'b1;
            load_value = {digits[DW-BCD_W-1:0], digit_in};
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            presc_q <= '0;
        end else if ((stop && state_q != RUNNING) ||
                     (!stop && start && entry_ok)) begin
            presc_q <= '0;
        end else if (presc_run) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state_q <= (state_q == RUNNING) ? PAUSED : IDLE;
                running <= 1'b0;
            end else if (start) begin
                if (state_q != ENTRY || !zero) begin
                    state_q <= RUNNING;
                    running <= 1'b1;
                end
            end else if (key_ok && entry_ok) begin
                state_q <= ENTRY;
                running <= 1'b0;
            end else if (tick && dec_zero) begin
                state_q <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_microwave_countdown.sv
module tb_microwave_countdown;

    localparam int MIN_DIGITS = 1;
    localparam int TPS        = 4;
    localparam int ND         = MIN_DIGITS + 2;
    localparam int DW         = 4 * ND;
    localparam int POW        = 10 ** ND;
    localparam int MAX_SECS   = (POW / 100 - 1) * 60 + 59;

    localparam int S_IDLE  = 0;
    localparam int S_ENTRY = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic          clock;
    logic          clear;
    logic          digit_valid;
    logic [3:0]    digit_in;
    logic          start;
    logic          stop;
    logic [DW-1:0] digits;
    logic [2:0]    state;
    logic          running;
    logic          zero;
    logic          done;

    int n_cmp;
    int n_err;

    // Reference model: time kept as plain seconds, keypad entry as a decimal number.
    int m_st;
    int m_secs;
    int m_entry;
    int m_presc;
    bit m_done;

    microwave_countdown #(.MIN_DIGITS(MIN_DIGITS), .TICKS_PER_SEC(TPS)) dut (
        .clock       (clock),
        .clear       (clear),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .start       (start),
        .stop        (stop),
        .digits      (digits),
        .state       (state),
        .running     (running),
        .zero        (zero),
        .done        (done)
    );

    always #5 clock = ~clock;

    function automatic int clamp(input int s);
        return (s > MAX_SECS) ? MAX_SECS : s;
    endfunction

    function automatic logic [DW-1:0] exp_digits();
        int v;
        logic [DW-1:0] r;
        v = (m_st == S_ENTRY) ? m_entry : (m_secs / 60) * 100 + (m_secs % 60);
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic void model_step(input logic c, input logic sp, input logic st,
                                       input logic dv, input logic [3:0] d);
        m_done = 1'b0;
        if (c) begin
            m_st = S_IDLE; m_secs = 0; m_entry = 0; m_presc = 0;
        end else if (sp) begin
            if (m_st == S_RUN) m_st = S_PAUSE;
            else begin
                m_st = S_IDLE; m_secs = 0; m_entry = 0; m_presc = 0;
            end
        end else if (st) begin
            case (m_st)
                S_IDLE, S_DONE: begin
                    m_secs = 30; m_presc = 0; m_st = S_RUN;
                end
                S_ENTRY: if (m_entry != 0) begin
                    m_secs  = clamp((m_entry / 100) * 60 + m_entry % 100);
                    m_entry = 0; m_presc = 0; m_st = S_RUN;
                end
                S_RUN: begin
                    m_presc = (m_presc + 1) % TPS;
                    if (m_presc == 0) m_secs = m_secs - 1;
                    m_secs = clamp(m_secs + 30);
                end
                default: m_st = S_RUN;
            endcase
        end else if (dv && d <= 4'd9 && (m_st == S_IDLE || m_st == S_ENTRY || m_st == S_DONE)) begin
            m_entry = ((m_st == S_ENTRY ? m_entry : 0) * 10 + int'(d)) % POW;
            m_st    = S_ENTRY;
        end else if (m_st == S_RUN) begin
            m_presc = (m_presc + 1) % TPS;
            if (m_presc == 0) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_st = S_DONE; m_done = 1'b1;
                end
            end
        end
    endfunction

    task automatic cycle(input logic c, input logic sp, input logic st,
                         input logic dv, input logic [3:0] d);
        clear = c; stop = sp; start = st; digit_valid = dv; digit_in = d;
        @(posedge clock);
        model_step(c, sp, st, dv, d);
        @(negedge clock);
        clear = 1'b0; stop = 1'b0; start = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
    endtask

    task automatic key(input logic [3:0] d);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (digits !== '0) begin n_err++; $display("FAIL reset_digits: got %h want 000", digits); end
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", zero); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
    endtask

    task automatic test_countdown();
        int pulses = 0;
        key(4'd1); key(4'd3); key(4'd0);
        n_cmp++; if (digits !== 12'h130) begin n_err++; $display("FAIL entry_130: got %h want 130", digits); end
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL entry_state: got %0d want 1", state); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (state !== 3'd2 || running !== 1'b1) begin n_err++; $display("FAIL start_run: got state %0d running %b want 2 1", state, running); end
        for (int i = 1; i <= 365; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            if (done) pulses++;
            if (i == 360) begin
                n_cmp++; if (digits !== '0 || state !== 3'd4 || done !== 1'b1) begin
                    n_err++; $display("FAIL countdown_end: got %h state %0d done %b want 000 4 1", digits, state, done);
                end
            end
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL done_pulses: got %0d want 1", pulses); end
        n_cmp++; if (state !== 3'd4 || digits !== '0) begin n_err++; $display("FAIL done_hold: got %0d %h want 4 000", state, digits); end
    endtask

    task automatic test_normalise();
        key(4'd9); key(4'd0);
        n_cmp++; if (digits !== 12'h090) begin n_err++; $display("FAIL entry_090: got %h want 090", digits); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h130 || state !== 3'd2) begin n_err++; $display("FAIL normalise: got %h state %0d want 130 2", digits, state); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        n_cmp++; if (digits !== 12'h234) begin n_err++; $display("FAIL entry_shift: got %h want 234", digits); end
        key(4'hB);
        n_cmp++; if (digits !== 12'h234 || state !== 3'd1) begin n_err++; $display("FAIL bad_key: got %h state %0d want 234 1", digits, state); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (digits !== '0 || state !== 3'd0) begin n_err++; $display("FAIL entry_cancel: got %h state %0d want 000 0", digits, state); end
    endtask

    task automatic test_quick_add();
        bit found = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h030 || state !== 3'd2) begin n_err++; $display("FAIL quick_start: got %h state %0d want 030 2", digits, state); end
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            if (digits === 12'h025) found = 1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL reach_025: got %h want 025 within 40 cycles", digits); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h055) begin n_err++; $display("FAIL plus30: got %h want 055", digits); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        key(4'd9); key(4'd5); key(4'd9);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h959) begin n_err++; $display("FAIL plus30_sat: got %h want 959", digits); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        key(4'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < TPS - 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h001) begin n_err++; $display("FAIL hold_001: got %h want 001", digits); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h030 || state !== 3'd2 || done !== 1'b0) begin
            n_err++; $display("FAIL tick_plus30: got %h state %0d done %b want 030 2 0", digits, state, done);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_pause();
        bit found = 0;
        int bad = 0;
        key(4'd1); key(4'd5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            if (digits === 12'h010) found = 1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL reach_010: got %h want 010 within 40 cycles", digits); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (state !== 3'd3 || running !== 1'b0) begin n_err++; $display("FAIL pause: got state %0d running %b want 3 0", state, running); end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            if (digits !== 12'h010 || state !== 3'd3) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL pause_hold: got %0d bad cycles (digits %h) want 0", bad, digits); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h010 || state !== 3'd2) begin n_err++; $display("FAIL resume: got %h state %0d want 010 2", digits, state); end
        for (int i = 0; i < TPS - 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h010) begin n_err++; $display("FAIL resume_presc: got %h want 010", digits); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (digits !== 12'h009) begin n_err++; $display("FAIL resume_tick: got %h want 009", digits); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL stop1: got %0d want 3", state); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        n_cmp++; if (state !== 3'd0 || digits !== '0) begin n_err++; $display("FAIL stop2: got %0d %h want 0 000", state, digits); end
    endtask

    task automatic test_clear_priority();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        key(4'd7);
        n_cmp++; if (digits !== 12'h030 || state !== 3'd2) begin n_err++; $display("FAIL key_in_run: got %h state %0d want 030 2", digits, state); end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (state !== 3'd0 || digits !== '0 || done !== 1'b0 || running !== 1'b0 || zero !== 1'b1) begin
            n_err++; $display("FAIL clear_mid_run: got %0d %h done %b run %b zero %b want 0 000 0 0 1", state, digits, done, running, zero);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_cmp++; if (state !== 3'd3 || digits !== 12'h030) begin n_err++; $display("FAIL stop_start: got %0d %h want 3 030", state, digits); end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_random();
        logic c, sp, st, dv;
        logic [3:0] d;
        for (int i = 0; i < 4000; i++) begin
            c  = ($urandom_range(0, 399) == 0);
            sp = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 19) == 0);
            dv = ($urandom_range(0, 5) == 0);
            d  = $urandom_range(0, 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            cycle(c, sp, st, dv, d);
            n_cmp++; if (digits !== exp_digits()) begin n_err++; $display("FAIL rand_digits @%0d: got %h want %h", i, digits, exp_digits()); end
            n_cmp++; if (state !== 3'(m_st)) begin n_err++; $display("FAIL rand_state @%0d: got %0d want %0d", i, state, m_st); end
            n_cmp++; if (running !== (m_st == S_RUN)) begin n_err++; $display("FAIL rand_running @%0d: got %b want %b", i, running, m_st == S_RUN); end
            n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL rand_done @%0d: got %b want %b", i, done, m_done); end
            n_cmp++; if (zero !== (exp_digits() == '0)) begin n_err++; $display("FAIL rand_zero @%0d: got %b want %b", i, zero, exp_digits() == '0); end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_st = S_IDLE; m_secs = 0; m_entry = 0; m_presc = 0; m_done = 1'b0;
        clock = 1'b0;
        clear = 1'b0; stop = 1'b0; start = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
        @(negedge clock);
        test_reset();
        test_countdown();
        test_normalise();
        test_quick_add();
        test_pause();
        test_clear_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
